cdc_handshake_transmitter: RTL and testbench



---
 rtl/cdc_handshake_transmitter.sv | 127 ++++++++++++
 tb/tb_cdc_handshake_transmitter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_transmitter.sv
// Source-domain side of a two-phase (toggle) request/acknowledge CDC channel.
// Optional one-word holding buffer: define CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN.
module cdc_handshake_transmitter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_valid,
  output logic             write_ready,
  output logic [WIDTH-1:0] cdc_data,
  output logic             cdc_request,
  input  logic             cdc_acknowledge,
  output logic             busy
);

  localparam logic [1:0] IDLE             = 2'd0;
  localparam logic [1:0] PENDING          = 2'd1;
`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
  localparam logic [1:0] PENDING_BUFFERED = 2'd2;
`endif

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [STAGES-1:0] ack_chain;
  logic [STAGES:0]   ack_shift;
  logic              ack_sync;
  logic              acknowledged;
  logic              launch;
  logic [WIDTH-1:0]  launch_word;

`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
  logic [WIDTH-1:0]  buffer_data;
  logic              buffer_load;
`endif

  // Top bit of the shift view is the last synchronizer stage; works for STAGES=1 too.
  assign ack_shift    = {ack_chain, cdc_acknowledge};
  assign ack_sync     = ack_shift[STAGES];
  assign acknowledged = (ack_sync == cdc_request);
  assign busy         = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ack_chain <= '0;
    end else begin
      ack_chain <= ack_shift[STAGES-1:0];
    end
  end

  always_comb begin
    write_ready = 1'b0;
    launch      = 1'b0;
    launch_word = write_data;
    state_next  = state;
`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
    buffer_load = 1'b0;
`endif
    case (state)
      IDLE: begin
        write_ready = 1'b1;
        if (write_valid) begin
          launch     = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
        write_ready = 1'b1;
        if (write_valid) begin
          if (acknowledged) begin
            launch = 1'b1;
          end else begin
            buffer_load = 1'b1;
            state_next  = PENDING_BUFFERED;
          end
        end else if (acknowledged) begin
          state_next = IDLE;
        end
`else
        write_ready = acknowledged;
        if (write_valid && acknowledged) begin
          launch = 1'b1;
        end else if (acknowledged) begin
          state_next = IDLE;
        end
`endif
      end
`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
      PENDING_BUFFERED: begin
        if (acknowledged) begin
          launch      = 1'b1;
          launch_word = buffer_data;
          state_next  = PENDING;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cdc_request <= 1'b0;
      cdc_data    <= '0;
    end else begin
      state <= state_next;
      if (launch) begin
        cdc_data    <= launch_word;
        cdc_request <= ~cdc_request;
      end
    end
  end

`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      buffer_data <= '0;
    end else if (buffer_load) begin
      buffer_data <= write_data;
    end
  end
`endif

endmodule

// File: tb/tb_cdc_handshake_transmitter.sv
// Scoreboard bench for cdc_handshake_transmitter: main instance (STAGES=2) plus
// loopback instances STAGES=1..5 for back-to-back throughput.
module tb_cdc_handshake_transmitter;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] write_data;
  logic       write_valid;
  logic       write_ready;
  logic [7:0] cdc_data;
  logic       cdc_request;
  logic       cdc_acknowledge;
  logic       busy;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [1:0] ack_mode;       // 0 manual, 1 loopback, 2 delayed by 7 cycles
  logic       ack_manual;
  logic [6:0] req_hist = '0;
  logic [7:0] expq[$];
  logic       b2b_valid;
  logic       b2b_final;

  cdc_handshake_transmitter #(.WIDTH(8), .STAGES(2)) u_dut (
    .clock          (clock),
    .resetn         (resetn),
    .write_data     (write_data),
    .write_valid    (write_valid),
    .write_ready    (write_ready),
    .cdc_data       (cdc_data),
    .cdc_request    (cdc_request),
    .cdc_acknowledge(cdc_acknowledge),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    req_hist <= {req_hist[5:0], cdc_request};
  end

  assign cdc_acknowledge = (ack_mode == 2'd0) ? ack_manual :
                           (ack_mode == 2'd1) ? cdc_request : req_hist[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receiver model / scoreboard monitor: each request toggle must carry the next queued word.
  logic       last_req = 1'b0;
  logic [7:0] last_exp = 8'h00;
  always @(negedge clock) begin
    if (!resetn) begin
      last_req = 1'b0;
      last_exp = 8'h00;
    end else if (cdc_request !== last_req) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got word %0h expected no transfer", cdc_data);
      end else begin
        last_exp = expq.pop_front();
        check("rx_word", cdc_data, last_exp);
      end
      last_req = cdc_request;
    end else if (busy) begin
      check("data_stable", cdc_data, last_exp);
    end
  end

  task automatic send(input logic [7:0] w);
    int n = 0;
    write_data  = w;
    write_valid = 1'b1;
    while (write_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: write_ready low for %0d cycles expected high", n);
      write_valid = 1'b0;
    end else begin
      expq.push_back(w);
      @(posedge clock);
      #1;
      write_valid = 1'b0;
      write_data  = 8'($urandom);
    end
  endtask

  task automatic scramble(input int n);
    repeat (n) begin
      @(negedge clock);
      write_data = 8'($urandom);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  for (genvar gs = 1; gs <= 5; gs++) begin : g_b2b
    logic [7:0]  cnt = 8'd0;
    logic        rdy;
    logic        req;
    logic        bz;
    logic [7:0]  dat;
    logic        prev_req = 1'b0;
    int unsigned last_cyc = 0;
    logic        done = 1'b0;

    cdc_handshake_transmitter #(.WIDTH(8), .STAGES(gs)) u_b2b (
      .clock          (clock),
      .resetn         (resetn),
      .write_data     (cnt),
      .write_valid    (b2b_valid && (cnt < 8'd16)),
      .write_ready    (rdy),
      .cdc_data       (dat),
      .cdc_request    (req),
      .cdc_acknowledge(req),
      .busy           (bz)
    );

    always @(negedge clock) begin
      if (!resetn) begin
        prev_req = 1'b0;
      end else if (req !== prev_req) begin
        check("b2b_word", dat, cnt);
        if (cnt != 8'd0) check("b2b_interval", cyc - last_cyc, gs + 1);
        last_cyc = cyc;
        prev_req = req;
        cnt      = cnt + 8'd1;
      end
      if (b2b_final && !done) begin
        done = 1'b1;
        check("b2b_count", cnt, 8'd16);
        check("b2b_idle", bz, 1'b0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    write_valid = 1'b0;
    write_data  = 8'h00;
    ack_mode    = 2'd0;
    ack_manual  = 1'b1;
    b2b_valid   = 1'b0;
    b2b_final   = 1'b0;

    // Reset with acknowledge held high.
    repeat (3) @(negedge clock);
    check("reset_request", cdc_request, 1'b0);
    check("reset_data", cdc_data, 8'h00);
    check("reset_ready", write_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    ack_manual = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    repeat (4) @(negedge clock);

    // First transfer must wait for a real acknowledge toggle.
    send(8'h77);
    check("first_request", cdc_request, 1'b1);
    repeat (6) begin
      @(negedge clock);
      check("no_ack_busy", busy, 1'b1);
      check("no_ack_ready", write_ready, 1'b0);
    end
    ack_manual = 1'b1;
    @(negedge clock);
    check("ack_s1_ready", write_ready, 1'b0);
    @(negedge clock);
    check("ack_s2_ready", write_ready, 1'b1);
    check("ack_s2_busy", busy, 1'b1);
    @(negedge clock);
    check("ack_done_busy", busy, 1'b0);

    // Single word in loopback.
    ack_mode = 2'd1;
    repeat (2) @(negedge clock);
    send(8'hA5);
    check("single_request", cdc_request, 1'b0);
    check("single_data", cdc_data, 8'hA5);
    @(negedge clock);
    check("single_ready_e0", write_ready, 1'b0);
    @(negedge clock);
    check("single_ready_e1", write_ready, 1'b0);
    @(negedge clock);
    check("single_ready_e2", write_ready, 1'b1);
    check("single_busy_e2", busy, 1'b1);
    @(negedge clock);
    check("single_busy_e3", busy, 1'b0);

    // Delayed receiver; write_data scrambled after each acceptance.
    repeat (10) @(negedge clock);
    ack_mode = 2'd2;
    @(negedge clock);
    send(8'h31); scramble(3);
    send(8'h42); scramble(3);
    send(8'h53); scramble(3);
    send(8'h64);
    wait_idle(60);

`ifdef CDC_HANDSHAKE_TRANSMITTER_BUFFER_EN
    repeat (10) @(negedge clock);
    begin
      int   n = 0;
      logic req_e1;
      send(8'h11);
      write_data  = 8'h22;
      write_valid = 1'b1;
      @(negedge clock);
      check("buf_ready_pending", write_ready, 1'b1);
      expq.push_back(8'h22);
      @(posedge clock);
      #1;
      write_valid = 1'b0;
      write_data  = 8'($urandom);
      req_e1 = cdc_request;
      while (cdc_request === req_e1 && n < 30) begin
        @(negedge clock);
        n++;
        if (cdc_request === req_e1) check("buf_ready_low", write_ready, 1'b0);
      end
      check("buf_launch_edge", n, 10);
      wait_idle(60);
    end
`endif

    // Reset one cycle after a launch.
    repeat (10) @(negedge clock);
    ack_mode = 2'd1;
    @(negedge clock);
    send(8'h3C);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check("midreset_request", cdc_request, 1'b0);
    check("midreset_data", cdc_data, 8'h00);
    check("midreset_busy", busy, 1'b0);
    check("midreset_ready", write_ready, 1'b1);
    @(posedge clock);
    #1 resetn = 1'b1;
    repeat (3) @(negedge clock);
    send(8'h5A);
    check("post_reset_request", cdc_request, 1'b1);
    wait_idle(20);

    // Back-to-back throughput for STAGES=1..5.
    @(negedge clock);
    b2b_valid = 1'b1;
    repeat (120) @(negedge clock);
    b2b_valid = 1'b0;
    b2b_final = 1'b1;
    repeat (2) @(negedge clock);

    check("queue_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
